tnn_neuron_seq: RTL

TNN_NEURON_SEQ -- requirements
Module: tnn_neuron_seq

---
 rtl/tnn_pkg.sv | 15 +
 rtl/tnn_acc_signed.sv | 33 +++
 rtl/tnn_neuron_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tnn_pkg.sv
// Shared types and sizing helpers for the ternary neuron datapath.
package tnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // Wide enough for N_POS*(2^W-1) and -N_NEG*(2^W-1) without overflow.
  function automatic int acc_width(input int w, input int n_pos, input int n_neg);
    return w + $clog2(n_pos + n_neg) + 1;
  endfunction

endpackage

// File: rtl/tnn_acc_signed.sv
// Signed accumulator: clears, adds or subtracts one unsigned W-bit operand per cycle.
module tnn_acc_signed #(
  parameter int W  = 2,
  parameter int AW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 add_en,
  input  logic                 sub_en,
  input  logic [W-1:0]         operand,
  output logic signed [AW-1:0] acc
);

  logic signed [AW-1:0] operand_ext;

  always_comb begin
    operand_ext = $signed({{(AW-W){1'b0}}, operand});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + operand_ext;
    end else if (sub_en) begin
      acc <= acc - operand_ext;
    end
  end

endmodule

// File: rtl/tnn_neuron_seq.sv
// Sequential ternary neuron: out_bit = sum(pos) > sum(neg), one channel per cycle.
// Define TNN_TIEBREAK_EN to resolve ties with the captured in_tie bit.
module tnn_neuron_seq
  import tnn_pkg::*;
#(
  parameter int N_POS = 3,
  parameter int N_NEG = 4,
  parameter int W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_POS*W-1:0] in_pos,
  input  logic [N_NEG*W-1:0] in_neg,
  input  logic             in_tie,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit
);

  localparam int AW   = acc_width(W, N_POS, N_NEG);
  localparam int N_CH = N_POS + N_NEG;
  localparam int CW   = $clog2(N_CH + 1);

  state_t               state_q, state_d;
  logic                 armed_q;
  logic [CW-1:0]        cnt_q;
  logic [N_POS*W-1:0]   pos_q;
  logic [N_NEG*W-1:0]   neg_q;
  logic                 out_bit_q;
  logic                 accept, add_en, sub_en, resolve;
  logic                 tie_val, decision;
  logic [W-1:0]         operand;
  logic signed [AW-1:0] acc;

  assign accept = in_valid && in_ready;

`ifdef TNN_TIEBREAK_EN
  logic tie_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tie_q <= 1'b0;
    end else if (accept) begin
      tie_q <= in_tie;
    end
  end

  assign tie_val = tie_q;
`else
  logic unused_tie;

  assign unused_tie = in_tie;
  assign tie_val    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ACC spends N_CH cycles applying channels, then one more edge registers the decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACC;
      ACC:     if (resolve) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // armed_q blocks acceptance on the first edge after reset release.
  always_comb begin
    in_ready  = (state_q == IDLE) && armed_q;
    out_valid = (state_q == DONE);
    out_bit   = out_bit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      pos_q     <= '0;
      neg_q     <= '0;
      out_bit_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        pos_q <= in_pos;
        neg_q <= in_neg;
        cnt_q <= '0;
      end else if (add_en || sub_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (resolve) begin
        out_bit_q <= decision;
      end
    end
  end

  always_comb begin
    add_en  = (state_q == ACC) && (cnt_q < CW'(N_POS));
    sub_en  = (state_q == ACC) && (cnt_q >= CW'(N_POS)) && (cnt_q < CW'(N_CH));
    resolve = (state_q == ACC) && (cnt_q == CW'(N_CH));
  end

  always_comb begin
    operand = '0;
    for (int unsigned k = 0; k < N_POS; k++) begin
      if (cnt_q == CW'(k)) operand = pos_q[k*W +: W];
    end
    for (int unsigned k = 0; k < N_NEG; k++) begin
      if (cnt_q == CW'(N_POS + k)) operand = neg_q[k*W +: W];
    end
  end

  always_comb begin
    if (acc == '0) begin
      decision = tie_val;
    end else begin
      decision = ~acc[AW-1];
    end
  end

  tnn_acc_signed #(
    .W  (W),
    .AW (AW)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .add_en  (add_en),
    .sub_en  (sub_en),
    .operand (operand),
    .acc     (acc)
  );

endmodule
